uriscv_fetch: RTL and testbench

// Instruction fetch sequencer for the uriscv core; sits directly upstream of execute/CSR.
// - Owns the PC and issues one instruction-bus read at a time.
// - Presents {pc, opcode, fault} to execute as the valid_i/pc_i/opcode_i source for uriscv_csr.
// - Consumes the CSR redirects (exception_o/exception_pc_o, mret/csr_mepc_o) and the ALU branch redirect.

---
 rtl/uriscv_fetch.sv | 186 ++++++++++++++++++
 tb/tb_uriscv_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uriscv_fetch.sv
// uriscv_fetch -- instruction fetch sequencer for the uriscv core.
//
// Owns the PC and runs one instruction-bus read at a time. The fetched word
// (or a fault marker) is held for execute until it is accepted. Redirects
// from the CSR unit (trap, mret) and the ALU (taken branch) are sampled only
// in the accept cycle.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   mem_req_o       instruction read request, held until ack or timeout
//   mem_addr_o      word-aligned read address, stable while mem_req_o=1
//   mem_ack_i       read complete (only meaningful while mem_req_o=1)
//   mem_rdata_i     read data, qualified by mem_ack_i
//   mem_err_i       bus error, qualified by mem_ack_i
//   inst_valid_o    instruction presented to execute
//   inst_ready_i    execute accepts the presented instruction
//   inst_pc_o       PC of the presented instruction
//   inst_opcode_o   opcode, zero when inst_fault_o=1
//   inst_fault_o    bus error, timeout or misaligned target
//   exception_i / exception_pc_i   trap redirect to mtvec
//   mret_i / mepc_i                return redirect to mepc
//   branch_i / branch_pc_i         taken branch redirect
module uriscv_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_pc_o,
   output logic [31:0] inst_opcode_o,
   output logic        inst_fault_o,
   input  logic        exception_i,
   input  logic [31:0] exception_pc_i,
   input  logic        mret_i,
   input  logic [31:0] mepc_i,
   input  logic        branch_i,
   input  logic [31:0] branch_pc_i
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic TIMEOUT_EN = (TIMEOUT != 0);
   // Value of the wait counter during the last request cycle allowed.
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t             state_r, state_s;
   logic [31:0]        pc_r, pc_s;
   logic               req_r, req_s;
   logic               valid_r, valid_s;
   logic [31:0]        opcode_r, opcode_s;
   logic               fault_r, fault_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [31:0]        redir_pc_s;

   // One PC register serves as both the bus address (in REQ) and the
   // presented PC (in HOLD); the two phases never overlap.
   assign mem_req_o     = req_r;
   assign mem_addr_o    = pc_r;
   assign inst_valid_o  = valid_r;
   assign inst_pc_o     = pc_r;
   assign inst_opcode_o = opcode_r;
   assign inst_fault_o  = fault_r;

   // Next-PC selection for the accept cycle: trap > mret > branch > sequential.
   always_comb begin
      redir_pc_s = pc_r + 32'd4;
      if (exception_i) begin
         redir_pc_s = exception_pc_i;
      end else if (mret_i) begin
         redir_pc_s = mepc_i;
      end else if (branch_i) begin
         redir_pc_s = branch_pc_i;
      end else begin
         redir_pc_s = pc_r + 32'd4;
      end
   end

   // Fetch FSM next-state and next-output logic.
   always_comb begin
      state_s  = state_r;
      pc_s     = pc_r;
      req_s    = req_r;
      valid_s  = valid_r;
      opcode_s = opcode_r;
      fault_s  = fault_r;
      cnt_s    = cnt_r;
      case (state_r)
         ST_BOOT: begin
            state_s  = ST_REQ;
            pc_s     = RESET_PC;
            req_s    = 1'b1;
            valid_s  = 1'b0;
            cnt_s    = '0;
         end
         ST_REQ: begin
            // req_r is high throughout REQ, so an ack here is always qualified.
            // An ack in the timeout cycle takes precedence over the timeout.
            if (mem_ack_i) begin
               state_s  = ST_HOLD;
               req_s    = 1'b0;
               valid_s  = 1'b1;
               if (mem_err_i) begin
                  opcode_s = 32'h0000_0000;
                  fault_s  = 1'b1;
               end else begin
                  opcode_s = mem_rdata_i;
                  fault_s  = 1'b0;
               end
            end else if (TIMEOUT_EN && (cnt_r == TMO_LAST)) begin
               state_s  = ST_HOLD;
               req_s    = 1'b0;
               valid_s  = 1'b1;
               opcode_s = 32'h0000_0000;
               fault_s  = 1'b1;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (valid_r && inst_ready_i) begin
               pc_s = redir_pc_s;
               if (redir_pc_s[1:0] != 2'b00) begin
                  // Misaligned target: present a fault without touching the bus.
                  state_s  = ST_HOLD;
                  req_s    = 1'b0;
                  valid_s  = 1'b1;
                  opcode_s = 32'h0000_0000;
                  fault_s  = 1'b1;
               end else begin
                  state_s  = ST_REQ;
                  req_s    = 1'b1;
                  valid_s  = 1'b0;
                  opcode_s = 32'h0000_0000;
                  fault_s  = 1'b0;
                  cnt_s    = '0;
               end
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s  = ST_BOOT;
            pc_s     = RESET_PC;
            req_s    = 1'b0;
            valid_s  = 1'b0;
            opcode_s = 32'h0000_0000;
            fault_s  = 1'b0;
            cnt_s    = '0;
         end
      endcase
   end

   // State and output registers; reset drops the bus request immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_BOOT;
         pc_r     <= RESET_PC;
         req_r    <= 1'b0;
         valid_r  <= 1'b0;
         opcode_r <= 32'h0000_0000;
         fault_r  <= 1'b0;
         cnt_r    <= '0;
      end else begin
         state_r  <= state_s;
         pc_r     <= pc_s;
         req_r    <= req_s;
         valid_r  <= valid_s;
         opcode_r <= opcode_s;
         fault_r  <= fault_s;
         cnt_r    <= cnt_s;
      end
   end

endmodule

// File: tb/tb_uriscv_fetch.sv
// Directed table-driven bench for uriscv_fetch (RESET_PC=0x100, TIMEOUT=4).
module tb_uriscv_fetch;

   logic        clk;
   logic        rst;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        mem_err_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_pc_o;
   logic [31:0] inst_opcode_o;
   logic        inst_fault_o;
   logic        exception_i;
   logic [31:0] exception_pc_i;
   logic        mret_i;
   logic [31:0] mepc_i;
   logic        branch_i;
   logic [31:0] branch_pc_i;

   int checks;
   int failures;

   uriscv_fetch #(
      .RESET_PC(32'h0000_0100),
      .TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ack_i     (mem_ack_i),
      .mem_rdata_i   (mem_rdata_i),
      .mem_err_i     (mem_err_i),
      .inst_valid_o  (inst_valid_o),
      .inst_ready_i  (inst_ready_i),
      .inst_pc_o     (inst_pc_o),
      .inst_opcode_o (inst_opcode_o),
      .inst_fault_o  (inst_fault_o),
      .exception_i   (exception_i),
      .exception_pc_i(exception_pc_i),
      .mret_i        (mret_i),
      .mepc_i        (mepc_i),
      .branch_i      (branch_i),
      .branch_pc_i   (branch_pc_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic        err;
      logic [31:0] rdata;
      logic        rdy;
      logic        exc;
      logic        mret;
      logic        br;
      logic [31:0] epc;
      logic [31:0] mpc;
      logic [31:0] bpc;
      logic        q_req;
      logic        q_val;
      logic [31:0] q_pc;
      logic [31:0] q_op;
      logic        q_f;
   } vec_t;

   localparam int NV = 31;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic ack, input logic err, input logic [31:0] rdata,
                               input logic rdy, input logic exc, input logic mret, input logic br,
                               input logic [31:0] epc, input logic [31:0] mpc, input logic [31:0] bpc,
                               input logic q_req, input logic q_val, input logic [31:0] q_pc,
                               input logic [31:0] q_op, input logic q_f);
      vec_t v;
      v.ack = ack; v.err = err; v.rdata = rdata; v.rdy = rdy;
      v.exc = exc; v.mret = mret; v.br = br;
      v.epc = epc; v.mpc = mpc; v.bpc = bpc;
      v.q_req = q_req; v.q_val = q_val; v.q_pc = q_pc; v.q_op = q_op; v.q_f = q_f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h0;
      inst_ready_i = 1'b0; exception_i = 1'b0; mret_i = 1'b0; branch_i = 1'b0;
      exception_pc_i = 32'h0; mepc_i = 32'h0; branch_pc_i = 32'h0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      // Columns: ack err rdata rdy exc mret br epc mpc bpc | req valid pc opcode fault
      tbl[0]  = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          0,0,32'h100,     32'h0,0);
      tbl[1]  = mk(1,0,32'hAAAA_0001,0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h100,     32'h0,0);
      tbl[2]  = mk(0,0,32'h0,        1,0,0,0, 32'h0,32'h0,32'h0,          0,1,32'h100,     32'hAAAA_0001,0);
      tbl[3]  = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h104,     32'h0,0);
      tbl[4]  = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h104,     32'h0,0);
      tbl[5]  = mk(1,0,32'hBBBB_0002,0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h104,     32'h0,0);
      tbl[6]  = mk(0,0,32'h0,        1,0,0,0, 32'h0,32'h0,32'h0,          0,1,32'h104,     32'hBBBB_0002,0);
      tbl[7]  = mk(1,0,32'hCCCC_0003,0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h108,     32'h0,0);
      // redirects without ready are ignored
      tbl[8]  = mk(0,0,32'h0,        0,1,1,1, 32'h200,32'h300,32'h400,    0,1,32'h108,     32'hCCCC_0003,0);
      tbl[9]  = mk(0,0,32'h0,        1,1,1,1, 32'h200,32'h300,32'h400,    0,1,32'h108,     32'hCCCC_0003,0);
      tbl[10] = mk(1,0,32'hDDDD_0004,0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h200,     32'h0,0);
      tbl[11] = mk(0,0,32'h0,        1,0,0,1, 32'h0,32'h0,32'h400,        0,1,32'h200,     32'hDDDD_0004,0);
      tbl[12] = mk(1,0,32'h0000_0011,0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h400,     32'h0,0);
      tbl[13] = mk(0,0,32'h0,        1,0,1,1, 32'h0,32'h500,32'h600,      0,1,32'h400,     32'h0000_0011,0);
      tbl[14] = mk(1,1,32'hDEAD_BEEF,0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h500,     32'h0,0);
      tbl[15] = mk(0,0,32'h0,        1,0,0,1, 32'h0,32'h0,32'h402,        0,1,32'h500,     32'h0,1);
      tbl[16] = mk(0,0,32'h0,        1,1,0,0, 32'hFFFF_FFFC,32'h0,32'h0,  0,1,32'h402,     32'h0,1);
      tbl[17] = mk(1,0,32'h0000_0022,0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'hFFFF_FFFC,32'h0,0);
      tbl[18] = mk(0,0,32'h0,        1,0,0,0, 32'h0,32'h0,32'h0,          0,1,32'hFFFF_FFFC,32'h0000_0022,0);
      // sequential wrap to 0, then four unanswered request cycles
      tbl[19] = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h0,       32'h0,0);
      tbl[20] = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h0,       32'h0,0);
      tbl[21] = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h0,       32'h0,0);
      tbl[22] = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h0,       32'h0,0);
      // timeout fault; late ack must be ignored
      tbl[23] = mk(1,0,32'h0000_0033,0,0,0,0, 32'h0,32'h0,32'h0,          0,1,32'h0,       32'h0,1);
      tbl[24] = mk(0,0,32'h0,        1,0,0,0, 32'h0,32'h0,32'h0,          0,1,32'h0,       32'h0,1);
      // ack in the fourth (timeout) cycle wins
      tbl[25] = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h4,       32'h0,0);
      tbl[26] = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h4,       32'h0,0);
      tbl[27] = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h4,       32'h0,0);
      tbl[28] = mk(1,0,32'h0000_0044,0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h4,       32'h0,0);
      tbl[29] = mk(0,0,32'h0,        1,0,0,0, 32'h0,32'h0,32'h0,          0,1,32'h4,       32'h0000_0044,0);
      tbl[30] = mk(0,0,32'h0,        0,0,0,0, 32'h0,32'h0,32'h0,          1,0,32'h8,       32'h0,0);

      drive_idle();
      rst = 1'b1;
      step();
      step();
      chk("rst_req",    {31'h0, mem_req_o},    32'h0);
      chk("rst_addr",   mem_addr_o,            32'h100);
      chk("rst_valid",  {31'h0, inst_valid_o}, 32'h0);
      chk("rst_pc",     inst_pc_o,             32'h100);
      chk("rst_opcode", inst_opcode_o,         32'h0);
      chk("rst_fault",  {31'h0, inst_fault_o}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         chk($sformatf("row%0d_req", i),   {31'h0, mem_req_o},    {31'h0, tbl[i].q_req});
         chk($sformatf("row%0d_valid", i), {31'h0, inst_valid_o}, {31'h0, tbl[i].q_val});
         if (tbl[i].q_req) begin
            chk($sformatf("row%0d_addr", i), mem_addr_o, tbl[i].q_pc);
         end
         if (tbl[i].q_val) begin
            chk($sformatf("row%0d_pc", i),     inst_pc_o,             tbl[i].q_pc);
            chk($sformatf("row%0d_opcode", i), inst_opcode_o,         tbl[i].q_op);
            chk($sformatf("row%0d_fault", i),  {31'h0, inst_fault_o}, {31'h0, tbl[i].q_f});
         end
         mem_ack_i      = tbl[i].ack;
         mem_err_i      = tbl[i].err;
         mem_rdata_i    = tbl[i].rdata;
         inst_ready_i   = tbl[i].rdy;
         exception_i    = tbl[i].exc;
         mret_i         = tbl[i].mret;
         branch_i       = tbl[i].br;
         exception_pc_i = tbl[i].epc;
         mepc_i         = tbl[i].mpc;
         branch_pc_i    = tbl[i].bpc;
         if (i < NV - 1) begin
            step();
         end
      end

      // Reset in the middle of a pending request: request drops at once.
      drive_idle();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_req",   {31'h0, mem_req_o},    32'h0);
      chk("midrst_addr",  mem_addr_o,            32'h100);
      chk("midrst_valid", {31'h0, inst_valid_o}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("boot_req", {31'h0, mem_req_o}, 32'h0);
      step();
      chk("restart_req",  {31'h0, mem_req_o}, 32'h1);
      chk("restart_addr", mem_addr_o,         32'h100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
